sd_dac_mc: RTL and testbench
============================

SD_DAC_MC -- requirements
Module: sd_dac_mc

Interface
REQ-001 Parameter WIDTH, default 16, meaning the sample width in bits (signed two's complement).
REQ-002 Parameter CHANNELS, default 2, meaning the number of independent modulator channels.
REQ-003 Parameter OSR, default 64, meaning modulator clocks per sample frame (OSR >= 4).
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port enable, input, 1 bit: when high, the modulators and the frame counter advance.
REQ-007 Port order2, input, 1 bit: 0 selects the 1st-order loop, 1 selects the 2nd-order loop; it is sampled only at a frame boundary.
REQ-008 Port in_data, input, WIDTH*CHANNELS bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port in_valid, input, 1 bit: in_data holds a valid frame.
REQ-010 Port in_ready, output, 1 bit: the holding buffer is empty.
REQ-011 Port clr_underrun, input, 1 bit: a synchronous clear of the underrun flag.
REQ-012 Port output_pdm_p, output, CHANNELS bits: the PDM bitstream, one bit per channel.
REQ-013 Port output_pdm_n, output, CHANNELS bits: the bitwise complement of output_pdm_p, registered.
REQ-014 Port underrun, output, 1 bit: a sticky flag meaning that a frame boundary passed with the holding buffer empty.

Function
REQ-015 The handshake SHALL complete on a clock edge where in_valid and in_ready are both high; the holding buffer then loads in_data and in_ready goes low on the next cycle.
REQ-016 A frame counter SHALL count 0..OSR-1 while enable is high and wrap to 0; the frame boundary is the cycle where the count equals OSR-1 and enable is high.
REQ-017 At a frame boundary with the holding buffer full:
- the active sample registers SHALL load from the holding buffer;
- the holding buffer SHALL be marked empty, and in_ready SHALL go high on the next cycle;
- order2 SHALL be latched into the active mode.
REQ-018 At a frame boundary with the holding buffer empty:
- the active samples SHALL be retained;
- underrun SHALL be set;
- the active mode SHALL still update from order2.
REQ-019 If a handshake and a frame boundary occur on the same edge, the previous holding content SHALL transfer to active and the new data SHALL occupy the holding buffer (in_ready stays low).
REQ-020 If clr_underrun and an underrun event occur on the same edge, the set SHALL win.
REQ-021 The 1st-order loop, per channel, SHALL operate as follows:
- u = x XOR 2^(WIDTH-1) (offset binary);
- {c, acc} = acc + u, where acc is WIDTH bits;
- output_pdm_p[k] = c, registered.
REQ-022 The 2nd-order loop, per channel, SHALL operate as follows:
- fb = +2^(WIDTH-1) when the previous output is 1, else -2^(WIDTH-1);
- i1 += x - fb;
- i2 += i1 - fb;
- the next output = (i2 >= 0);
- i1 and i2 are signed WIDTH+4 bits and saturate at their extremes, with no wrap-around.
REQ-023 A change of active mode SHALL clear acc, i1 and i2 of every channel on the same edge as the mode update.
REQ-024 While enable is low:
- the frame counter, the integrators and the outputs SHALL hold;
- the handshake SHALL remain functional.
REQ-025 Latency: the first PDM bit that reflects a newly active sample SHALL appear on output_pdm_p one cycle after the frame boundary.
REQ-026 Channels SHALL be independent; there SHALL be no cross-channel state.

Reset
REQ-027 When reset is low, the following SHALL clear asynchronously, regardless of clk:
- acc, i1, i2 and the frame counter to 0;
- the active samples to 0 and the active mode to 1st-order;
- the holding buffer to empty;
- output_pdm_p to 0, output_pdm_n to all ones, and underrun to 0.
REQ-028 in_ready SHALL be 0 while reset is low and SHALL be 1 on the first clock after reset deasserts.
REQ-029 Reset asserted mid-frame SHALL discard any pending holding data with no partial-frame output.

Verification
REQ-030 Reset behaviour: hold reset low for 200 ns with a 10 MHz clock -> output_pdm_p=0, output_pdm_n=all ones, in_ready=0, underrun=0; one clock after release -> in_ready=1.
REQ-031 1st-order mid-scale: enable=1, order2=0, x=0 on all channels -> after the first boundary, output_pdm_p[k] alternates 0,1,0,1..., giving exactly OSR/2 ones per frame.
REQ-032 1st-order near full scale: x=+32767 (WIDTH=16) -> 63 or 64 ones per 64-cycle frame; x=-32768 -> 0 ones.
REQ-033 2nd-order density: order2=1, x=+16384 -> the ones density over 16 frames is within 75% ±2%; integrators never exceed their saturation limits.
REQ-034 Underrun: supply one frame, then hold in_valid low across the next boundary -> underrun=1 and the output density is unchanged; clr_underrun=1 for one cycle -> underrun=0.
REQ-035 Backpressure and same-edge transfer: hold in_valid high with a new value each cycle -> exactly one handshake per frame (counted over 8 frames) after the buffer fills; a handshake on the boundary edge -> the old data becomes active and the new data is held.

Source files
------------

// File: rtl/sd_dac_mc.sv
// Multi-channel sigma-delta PDM DAC: a one-deep holding buffer feeds per-channel
// 1st/2nd-order modulators that pick up a new sample once per OSR-clock frame.

// Per-channel modulator. There is no shared state, so channels stay independent.
module sd_dac_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] x,
  output logic             pdm_p,
  output logic             pdm_n
);
  localparam int IW = WIDTH + 4;  // integrator width
  localparam int EW = IW + 2;     // headroom for one add/sub step before saturation
  localparam logic signed [EW-1:0] HI  = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [EW-1:0] LO  = {3'b111, {(IW-1){1'b0}}};
  localparam logic signed [EW-1:0] FBP = {{(EW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]        acc;
  logic [WIDTH:0]          sum;
  logic signed [IW-1:0]    i1, i2, i1n, i2n;
  logic signed [EW-1:0]    xs, fb, t1, t2;

  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > HI)      return HI[IW-1:0];
    else if (v < LO) return LO[IW-1:0];
    else             return v[IW-1:0];
  endfunction

  // Next-state arithmetic for both loop orders.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, x ^ {1'b1, {(WIDTH-1){1'b0}}}};
    xs  = EW'($signed(x));
    fb  = pdm_p ? FBP : -FBP;
    t1  = EW'(i1) + xs - fb;
    i1n = sat(t1);
    t2  = EW'(i2) + EW'(i1n) - fb;
    i2n = sat(t2);
  end

  // Loop state and registered complementary outputs; a mode change restarts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      i1    <= '0;
      i2    <= '0;
      pdm_p <= 1'b0;
      pdm_n <= 1'b1;
    end else if (enable) begin
      if (clear) begin
        acc   <= '0;
        i1    <= '0;
        i2    <= '0;
        pdm_p <= 1'b0;
        pdm_n <= 1'b1;
      end else if (mode) begin
        i1    <= i1n;
        i2    <= i2n;
        pdm_p <= ~i2n[IW-1];
        pdm_n <= i2n[IW-1];
      end else begin
        acc   <= sum[WIDTH-1:0];
        pdm_p <= sum[WIDTH];
        pdm_n <= ~sum[WIDTH];
      end
    end
  end
endmodule

module sd_dac_mc #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int OSR      = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      order2,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      clr_underrun,
  output logic [CHANNELS-1:0]       output_pdm_p,
  output logic [CHANNELS-1:0]       output_pdm_n,
  output logic                      underrun
);
  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

  logic [CW-1:0]                    cnt;
  logic                             boundary, hs, load, mode_q, mode_chg, full, rdy;
  logic [CHANNELS-1:0][WIDTH-1:0]   hold_q, act_q, x_sel;

  assign in_ready = rdy;
  assign hs       = in_valid & rdy;
  assign boundary = enable && (cnt == CW'(OSR - 1));
  assign load     = boundary & full;
  assign mode_chg = boundary & (order2 != mode_q);
  // On the loading boundary the modulators already see the new sample, so the
  // first PDM bit for it appears right after the boundary edge.
  assign x_sel    = load ? hold_q : act_q;

  // Frame counter, frozen while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (enable) cnt <= boundary ? '0 : cnt + 1'b1;
  end

  // Holding buffer; ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      full   <= 1'b0;
      rdy    <= 1'b0;
    end else if (hs) begin
      hold_q <= in_data;
      full   <= 1'b1;
      rdy    <= 1'b0;
    end else if (load) begin
      full   <= 1'b0;
      rdy    <= 1'b1;
    end else begin
      rdy    <= ~full;
    end
  end

  // Active samples and loop mode, updated only at frame boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q  <= '0;
      mode_q <= 1'b0;
    end else if (boundary) begin
      mode_q <= order2;
      if (full) act_q <= hold_q;
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 underrun <= 1'b0;
    else if (boundary && !full) underrun <= 1'b1;
    else if (clr_underrun)      underrun <= 1'b0;
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    sd_dac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .mode   (mode_q),
      .clear  (mode_chg),
      .x      (x_sel[k]),
      .pdm_p  (output_pdm_p[k]),
      .pdm_n  (output_pdm_n[k])
    );
  end
endmodule

// File: tb/tb_sd_dac_mc.sv
// Bench for sd_dac_mc: reference counts of PDM ones derived from sample values.
module tb_sd_dac_mc;
  localparam int W = 16, CH = 2, OSR = 64;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, order2 = 1'b0;
  logic in_valid = 1'b0, clr_underrun = 1'b0;
  logic [W*CH-1:0] in_data = '0;
  logic in_ready, underrun;
  logic [CH-1:0] pdm_p, pdm_n;

  int nvec = 0, nerr = 0, ecnt = 0, hs_cnt = 0;
  int ones [CH];

  always #50 clk = ~clk;  // 10 MHz

  sd_dac_mc #(.WIDTH(W), .CHANNELS(CH), .OSR(OSR)) dut (
    .clk(clk), .reset(reset), .enable(enable), .order2(order2),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clr_underrun(clr_underrun), .output_pdm_p(pdm_p), .output_pdm_n(pdm_n),
    .underrun(underrun)
  );

  // 1st-order: ones after n enabled edges from reset = floor(total offset-binary
  // input / 2^W); the first OSR-1 edges see the reset sample 0, the rest see x.
  function automatic longint model1(int n, int x);
    longint u = longint'(x) + 32768;
    if (n < OSR) return (longint'(n) * 32768) / 65536;
    return (longint'(OSR - 1) * 32768 + longint'(n - OSR + 1) * u) / 65536;
  endfunction

  task automatic tick();
    logic hs, en;
    hs = in_valid && in_ready;
    en = enable;
    @(posedge clk); #1;
    if (hs) hs_cnt++;
    if (en) begin
      ecnt++;
      for (int k = 0; k < CH; k++) ones[k] += int'(pdm_p[k]);
    end
    nvec++;
    if (pdm_n !== ~pdm_p) begin
      nerr++;
      $display("FAIL pdm_n_complement: got %b want %b", pdm_n, ~pdm_p);
    end
  endtask

  task automatic run_to(int n);
    for (int g = 0; g < 100000 && ecnt < n; g++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; clr_underrun = 1'b0; order2 = 1'b0;
    #200;
    @(negedge clk);
    reset = 1'b1;
    ecnt = 0; hs_cnt = 0;
    for (int k = 0; k < CH; k++) ones[k] = 0;
    tick();
  endtask

  task automatic push(int x0, int x1);
    in_data  = {16'(x1), 16'(x0)};
    in_valid = 1'b1;
    for (int g = 0; g < 200 && !in_ready; g++) tick();
    nvec++;
    if (!in_ready) begin
      nerr++;
      $display("FAIL push_timeout: in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #20 reset = 1'b0;  // asynchronous, between clock edges
    #1;
    nvec++; if (pdm_p !== '0)  begin nerr++; $display("FAIL rst_pdm_p: got %b want 0", pdm_p); end
    nvec++; if (pdm_n !== '1)  begin nerr++; $display("FAIL rst_pdm_n: got %b want 11", pdm_n); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0", in_ready); end
    nvec++; if (underrun !== 1'b0) begin nerr++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    #199;
    @(negedge clk) reset = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready_pre_edge: got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
    // Mid-frame reset with a pending sample: the sample must be discarded.
    ecnt = 0; ones[0] = 0; ones[1] = 0;
    push(32767, 32767);
    enable = 1'b1;
    run_to(30);
    push(32767, 32767);
    #20 reset = 1'b0;
    #1;
    nvec++; if (pdm_p !== '0 || pdm_n !== '1) begin nerr++; $display("FAIL midreset_out: got p=%b n=%b want p=00 n=11", pdm_p, pdm_n); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL midreset_ready: got %b want 0", in_ready); end
    enable = 1'b0;
    #200;
    @(negedge clk) reset = 1'b1;
    ecnt = 0; ones[0] = 0; ones[1] = 0;
    tick();
    enable = 1'b1;
    run_to(OSR + 1);
    enable = 1'b0;
    nvec++; if (ones[0] !== 32) begin nerr++; $display("FAIL midreset_discard: ones got %0d want 32", ones[0]); end
    nvec++; if (underrun !== 1'b1) begin nerr++; $display("FAIL midreset_underrun: got %b want 1", underrun); end
  endtask

  task automatic test_mid_scale();
    int base [CH];
    int flips [CH];
    logic [CH-1:0] prev;
    do_reset();
    push(0, 0);
    enable = 1'b1;
    run_to(OSR);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < CH; k++) begin base[k] = ones[k]; flips[k] = 0; end
      for (int c = 0; c < OSR; c++) begin
        prev = pdm_p;
        tick();
        for (int k = 0; k < CH; k++) if (pdm_p[k] != prev[k]) flips[k]++;
      end
      for (int k = 0; k < CH; k++) begin
        nvec++;
        if (ones[k] - base[k] !== OSR / 2) begin
          nerr++; $display("FAIL mid_ones ch%0d frame%0d: got %0d want %0d", k, f, ones[k] - base[k], OSR / 2);
        end
        nvec++;
        if (flips[k] !== OSR) begin
          nerr++; $display("FAIL mid_alternate ch%0d frame%0d: toggles got %0d want %0d", k, f, flips[k], OSR);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_full_scale();
    int b0, b1;
    do_reset();
    push(32767, -32768);
    enable = 1'b1;
    run_to(OSR);
    b0 = ones[0]; b1 = ones[1];
    run_to(2 * OSR);
    enable = 1'b0;
    nvec++; if (ones[0] - b0 < 63 || ones[0] - b0 > 64) begin nerr++; $display("FAIL fs_pos: ones got %0d want 63..64", ones[0] - b0); end
    nvec++; if (ones[1] - b1 !== 0) begin nerr++; $display("FAIL fs_neg: ones got %0d want 0", ones[1] - b1); end
    nvec++; if (longint'(ones[0]) !== model1(2 * OSR, 32767)) begin nerr++; $display("FAIL fs_pos_total: got %0d want %0d", ones[0], model1(2 * OSR, 32767)); end
    nvec++; if (longint'(ones[1]) !== model1(2 * OSR, -32768)) begin nerr++; $display("FAIL fs_neg_total: got %0d want %0d", ones[1], model1(2 * OSR, -32768)); end
  endtask

  task automatic test_random_first_order();
    int xs [CH];
    int n;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int k = 0; k < CH; k++) xs[k] = int'($urandom_range(0, 65535)) - 32768;
      push(xs[0], xs[1]);
      n = OSR + int'($urandom_range(1, 3 * OSR));
      for (int g = 0; g < 20000 && ecnt < n; g++) begin
        enable = ($urandom_range(0, 3) != 0);
        tick();
      end
      enable = 1'b0;
      for (int k = 0; k < CH; k++) begin
        nvec++;
        if (longint'(ones[k]) !== model1(n, xs[k])) begin
          nerr++; $display("FAIL rand1 ch%0d x=%0d n=%0d: ones got %0d want %0d", k, xs[k], n, ones[k], model1(n, xs[k]));
        end
      end
    end
  endtask

  task automatic test_second_order();
    int xs [CH];
    int base [CH];
    int expn, d;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      order2 = 1'b1;
      xs[0] = (it == 0) ? 16384 : int'($urandom_range(0, 32768)) - 16384;
      xs[1] = int'($urandom_range(0, 32768)) - 16384;
      push(xs[0], xs[1]);
      enable = 1'b1;
      run_to(OSR);
      for (int k = 0; k < CH; k++) base[k] = ones[k];
      run_to(OSR + 16 * OSR);
      enable = 1'b0;
      for (int k = 0; k < CH; k++) begin
        expn = ((xs[k] + 32768) * 16 * OSR + 32768) / 65536;
        d = ones[k] - base[k] - expn;
        nvec++;
        if (d > 20 || d < -20) begin
          nerr++; $display("FAIL order2_density ch%0d x=%0d: ones got %0d want %0d+-20", k, xs[k], ones[k] - base[k], expn);
        end
      end
    end
  endtask

  task automatic test_underrun();
    int b0;
    do_reset();
    push(0, 0);
    enable = 1'b1;
    run_to(OSR);
    nvec++; if (underrun !== 1'b0) begin nerr++; $display("FAIL ur_loaded: got %b want 0", underrun); end
    b0 = ones[0];
    run_to(2 * OSR - 1);
    nvec++; if (underrun !== 1'b0) begin nerr++; $display("FAIL ur_pre_boundary: got %b want 0", underrun); end
    run_to(2 * OSR);
    nvec++; if (underrun !== 1'b1) begin nerr++; $display("FAIL ur_set: got %b want 1", underrun); end
    nvec++; if (ones[0] - b0 !== OSR / 2) begin nerr++; $display("FAIL ur_density: ones got %0d want %0d", ones[0] - b0, OSR / 2); end
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    nvec++; if (underrun !== 1'b0) begin nerr++; $display("FAIL ur_clear: got %b want 0", underrun); end
    run_to(3 * OSR - 1);
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    nvec++; if (underrun !== 1'b1) begin nerr++; $display("FAIL ur_set_wins: got %b want 1", underrun); end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    int h0;
    do_reset();
    enable = 1'b1;
    in_valid = 1'b1;
    for (int g = 0; g < 20000 && ecnt < 9 * OSR; g++) begin
      in_data = {$urandom(), $urandom()} >> 32;
      if (ecnt == OSR) h0 = hs_cnt;
      tick();
    end
    in_valid = 1'b0;
    enable = 1'b0;
    nvec++; if (hs_cnt - h0 !== 8) begin nerr++; $display("FAIL b2b_handshakes: got %0d want 8", hs_cnt - h0); end
  endtask

  task automatic test_same_edge();
    int b0;
    do_reset();
    push(-32768, -32768);
    enable = 1'b1;
    run_to(2 * OSR - 1);
    in_data = {16'sd32767, 16'sd32767};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL same_held: in_ready got %b want 0", in_ready); end
    nvec++; if (underrun !== 1'b1) begin nerr++; $display("FAIL same_underrun: got %b want 1", underrun); end
    run_to(3 * OSR - 1);
    nvec++; if (ones[0] !== 31) begin nerr++; $display("FAIL same_old_active: ones got %0d want 31", ones[0]); end
    run_to(3 * OSR);
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL same_transfer: in_ready got %b want 1", in_ready); end
    b0 = ones[1];
    run_to(4 * OSR);
    enable = 1'b0;
    nvec++; if (ones[1] - b0 < 63 || ones[1] - b0 > 64) begin nerr++; $display("FAIL same_new_active: ones got %0d want 63..64", ones[1] - b0); end
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mid_scale();
    test_full_scale();
    test_random_first_order();
    test_second_order();
    test_underrun();
    test_back_to_back();
    test_same_edge();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
